spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- Receive end of the team's single-clock SPI link: captures a serial frame on mosi, framed by active-low slave select ss, MSB first, one bit per clk.
- Presents the parallel word with a one-cycle valid strobe, or flags a malformed frame with a one-cycle err strobe.
- Sits on the peripheral side opposite the SPI master; state and count are exported for debug, as on the master.

Parameters:
- DATA_W, 4, payload bits per frame (>= 2).
- CNT_W, $clog2(DATA_W+2), width of the bit counter; a derived localparam, not overridden.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- ss  input  1  slave select, active-low; low = frame in progress.
- mosi  input  1  serial data, sampled on clk while frame active.
- data_out  output  DATA_W  last good received word, MSB = first bit received.
- valid  output  1  one-cycle pulse: data_out updated with a good frame.
- err  output  1  one-cycle pulse: frame discarded (short, long, or parity fail).
- count  output  CNT_W  bits captured in the current frame.
- state  output  2  FSM state: IDLE=2'b00, RECV=2'b01, DONE=2'b10, ERR=2'b11.

Behaviour:
- Reset (rst=0, async): data_out=0, valid=0, err=0, count=0, state=IDLE, shift register=0, ovf flag=0, ss_q=0.
- ss_q holds the previous-cycle ss and is updated every cycle. Because ss_q resets to 0, ss must be seen high at least once after reset before any frame is accepted.
- IDLE:
  - On ss=0 && ss_q=1 (falling edge), go to RECV, count<=0, ovf<=0.
  - No sample is taken on the edge cycle.
  - ss low without a prior high keeps the FSM in IDLE.
- RECV, ss=0:
  - Shift mosi into the LSB of the shift register (shift left) and count<=count+1.
  - count saturates at FLEN (FLEN=DATA_W, or DATA_W+1 with parity).
  - A sample taken when count==FLEN sets sticky ovf and is not shifted.
- RECV, ss=1 (frame end):
  - If count==FLEN, ovf=0 (and parity OK): data_out<=payload, state<=DONE.
  - Otherwise: state<=ERR and data_out is unchanged.
  - The ss=1 cycle does not sample mosi.
- DONE: valid=1 for exactly this cycle, then state<=IDLE.
- ERR: err=1 for exactly this cycle, then state<=IDLE.
- valid and err are registered decodes of state; they are never high together.
- Latency: valid/err rise 1 cycle after the first cycle with ss=1; data_out is stable in that same cycle.
- A falling edge of ss during DONE or ERR is missed. That frame is ignored until ss returns high and falls again.
- count keeps its final value through DONE/ERR and clears on the next frame start.
- Reset mid-frame: immediate return to reset values. The partial frame produces no valid or err.

Optional Feature:
- Macro: SPI_SLAVE_RX_PARITY_EN.
- When defined:
  - FLEN=DATA_W+1; the final bit is even parity (XOR of all FLEN bits must be 0).
  - A length-correct frame with a mismatch goes to ERR.
  - The parity bit is not stored in data_out.
- When undefined: FLEN=DATA_W and no parity check.

Test Plan:
- Release rst, ss=1 for 2 cycles, then ss=0 for 4 cycles with mosi=1,1,0,1, then ss=1 -> one cycle later state=DONE, valid=1 for 1 cycle, data_out=4'b1101, count=4; next cycle state=IDLE.
- After the first test, send a 3-bit frame 1,0,1 -> err=1 for 1 cycle, valid stays 0, data_out remains 4'b1101, count=3.
- Send a 5-bit frame 0,0,1,1,1 -> err=1, count=4 (saturated), data_out unchanged.
- Release rst with ss already 0 and mosi toggling for 8 cycles -> state stays IDLE, no valid/err; after ss high then low, a normal 4'b0110 frame is received correctly.
- Drive rst=0 after 2 bits of a frame -> all outputs go to reset values without waiting for clk; after release with ss=1, no valid/err is ever produced for the aborted frame.
- With SPI_SLAVE_RX_PARITY_EN: send 1,1,0,1,1 -> valid, data_out=4'b1101; send 1,1,0,1,0 -> err, data_out unchanged.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// Signal bundle between an SPI master (or bench) and spi_slave_rx.
// The master drives the serial side and observes the parallel word and debug state.
interface spi_slave_rx_if #(
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 2);

  logic              ss;
  logic              mosi;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              err;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;

  modport master (
    output ss, mosi,
    input  data_out, valid, err, count, state
  );

  modport slave (
    input  ss, mosi,
    output data_out, valid, err, count, state
  );
endinterface

// File: rtl/spi_slave_rx.sv
// Single-clock SPI receive end: MSB-first frame framed by active-low ss, one-cycle valid/err strobes.
// Optional even-parity trailer bit enabled by defining SPI_SLAVE_RX_PARITY_EN.
module spi_slave_rx #(
  parameter int unsigned DATA_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_rx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 2);
`ifdef SPI_SLAVE_RX_PARITY_EN
  localparam int unsigned FLEN  = DATA_W + 1;
`else
  localparam int unsigned FLEN  = DATA_W;
`endif

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RECV = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLEN-1:0]   shreg_q, shreg_d;
  logic              ovf_q, ovf_d;
  logic              ss_q, ss_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] payload_c;
  logic              parity_ok_c;

  // Payload view of the shift register; parity bit (if any) is the last one shifted in.
`ifdef SPI_SLAVE_RX_PARITY_EN
  assign payload_c   = shreg_q[FLEN-1:1];
  assign parity_ok_c = ~(^shreg_q);
`else
  assign payload_c   = shreg_q;
  assign parity_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
      ss_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
      ss_q    <= ss_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    ovf_d   = ovf_q;
    ss_d    = bus.ss;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a genuine high-to-low transition starts a frame; no sample on this cycle.
        if (!bus.ss && ss_q) begin
          state_d = ST_RECV;
          count_d = '0;
          ovf_d   = 1'b0;
          shreg_d = '0;
        end
      end
      ST_RECV: begin
        if (!bus.ss) begin
          if (count_q == CNT_W'(FLEN)) begin
            ovf_d = 1'b1;
          end else begin
            shreg_d = {shreg_q[FLEN-2:0], bus.mosi};
            count_d = count_q + CNT_W'(1);
          end
        end else if ((count_q == CNT_W'(FLEN)) && !ovf_q && parity_ok_c) begin
          data_d  = payload_c;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    // Strobes are registered decodes of the next state, so they track DONE/ERR exactly.
    valid_d = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.count    = count_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of frames plus hand-written reset and missed-edge sequences.
module tb_spi_slave_rx;

  localparam int unsigned DATA_W = 4;
`ifdef SPI_SLAVE_RX_PARITY_EN
  localparam int FLEN = DATA_W + 1;
  localparam int NV   = 6;
`else
  localparam int FLEN = DATA_W;
  localparam int NV   = 8;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_slave_rx_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_rx #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;
    int         n;
    logic       exp_valid;
    logic [3:0] exp_data;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame: ensure ss high, falling-edge cycle (mosi=1, must be ignored), n bits, then ss high.
  task automatic send_frame(input logic [7:0] bits, input int n);
    bus.ss   = 1'b1;
    bus.mosi = 1'b1;
    step();
    bus.ss   = 1'b0;
    bus.mosi = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      bus.mosi = bits[n-1-i];
      step();
    end
    bus.ss   = 1'b1;
    bus.mosi = 1'b1;
    step();
  endtask

  task automatic check_end(input string tag, input logic ev, input logic [3:0] ed, input int ec);
    chk({tag, " state"}, 32'(bus.state), ev ? 32'd2 : 32'd3);
    chk({tag, " valid"}, 32'(bus.valid), 32'(ev));
    chk({tag, " err"},   32'(bus.err),   32'(!ev));
    chk({tag, " data"},  32'(bus.data_out), 32'(ed));
    chk({tag, " count"}, 32'(bus.count), 32'(ec));
    step();
    chk({tag, " idle"},     32'(bus.state), 32'd0);
    chk({tag, " strobes"},  32'({bus.valid, bus.err}), 32'd0);
    chk({tag, " cnt hold"}, 32'(bus.count), 32'(ec));
  endtask

  initial begin
    checks = 0;
    errors = 0;

`ifdef SPI_SLAVE_RX_PARITY_EN
    vecs[0] = '{bits: 8'b11011,  n: 5, exp_valid: 1'b1, exp_data: 4'b1101, exp_cnt: 5};
    vecs[1] = '{bits: 8'b11010,  n: 5, exp_valid: 1'b0, exp_data: 4'b1101, exp_cnt: 5};
    vecs[2] = '{bits: 8'b01100,  n: 5, exp_valid: 1'b1, exp_data: 4'b0110, exp_cnt: 5};
    vecs[3] = '{bits: 8'b1101,   n: 4, exp_valid: 1'b0, exp_data: 4'b0110, exp_cnt: 4};
    vecs[4] = '{bits: 8'b111111, n: 6, exp_valid: 1'b0, exp_data: 4'b0110, exp_cnt: 5};
    vecs[5] = '{bits: 8'b00011,  n: 5, exp_valid: 1'b1, exp_data: 4'b0001, exp_cnt: 5};
`else
    vecs[0] = '{bits: 8'b1101,    n: 4, exp_valid: 1'b1, exp_data: 4'b1101, exp_cnt: 4};
    vecs[1] = '{bits: 8'b101,     n: 3, exp_valid: 1'b0, exp_data: 4'b1101, exp_cnt: 3};
    vecs[2] = '{bits: 8'b00111,   n: 5, exp_valid: 1'b0, exp_data: 4'b1101, exp_cnt: 4};
    vecs[3] = '{bits: 8'b0110,    n: 4, exp_valid: 1'b1, exp_data: 4'b0110, exp_cnt: 4};
    vecs[4] = '{bits: 8'b1000,    n: 4, exp_valid: 1'b1, exp_data: 4'b1000, exp_cnt: 4};
    vecs[5] = '{bits: 8'b0,       n: 0, exp_valid: 1'b0, exp_data: 4'b1000, exp_cnt: 0};
    vecs[6] = '{bits: 8'b1111111, n: 7, exp_valid: 1'b0, exp_data: 4'b1000, exp_cnt: 4};
    vecs[7] = '{bits: 8'b0001,    n: 4, exp_valid: 1'b1, exp_data: 4'b0001, exp_cnt: 4};
`endif

    // Reset with ss already low; release and toggle mosi: no frame may start.
    rst      = 1'b0;
    bus.ss   = 1'b0;
    bus.mosi = 1'b0;
    step();
    step();
    chk("rst state", 32'(bus.state), 32'd0);
    chk("rst count", 32'(bus.count), 32'd0);
    chk("rst data",  32'(bus.data_out), 32'd0);
    chk("rst strobes", 32'({bus.valid, bus.err}), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.mosi = i[0];
      step();
      chk("ss low idle", 32'({bus.state, bus.valid, bus.err}), 32'd0);
    end

    for (int v = 0; v < NV; v++) begin
      send_frame(vecs[v].bits, vecs[v].n);
      check_end($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_data, vecs[v].exp_cnt);
    end

    // Falling edge of ss while in DONE is missed; held-low frame must be ignored.
    send_frame(8'b0110 << (FLEN - 4), FLEN);
    chk("miss done", 32'(bus.state), 32'd2);
    bus.ss = 1'b0;
    for (int i = 0; i < FLEN + 2; i++) begin
      bus.mosi = ~i[0];
      step();
      chk("miss idle", 32'({bus.state, bus.valid, bus.err}), 32'd0);
    end
`ifdef SPI_SLAVE_RX_PARITY_EN
    send_frame(8'b10100, 5);
`else
    send_frame(8'b1010, 4);
`endif
    check_end("after miss", 1'b1, 4'b1010, FLEN);

    // Asynchronous reset two bits into a frame.
    bus.ss   = 1'b1;
    step();
    bus.ss   = 1'b0;
    step();
    bus.mosi = 1'b1;
    step();
    step();
    chk("pre-abort count", 32'(bus.count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("abort state", 32'(bus.state), 32'd0);
    chk("abort count", 32'(bus.count), 32'd0);
    chk("abort data",  32'(bus.data_out), 32'd0);
    chk("abort strobes", 32'({bus.valid, bus.err}), 32'd0);
    step();
    bus.ss = 1'b1;
    rst    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post-abort quiet", 32'({bus.state, bus.valid, bus.err}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
